// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for the asynchronous FIFO.
// It pops the FIFO whenever there is room in a 2-entry registered buffer.
// Popped words go to the consumer on a valid/ready stream in pop order.
// The pop decision never looks at m_ready, so there is no combinational path
// from the consumer back to the FIFO.
//
// Ports:
//   rclk, rrst  read-domain clock; synchronous active-high reset
//   rempty      FIFO empty flag
//   rdata       FIFO read data (combinational read at the current address)
//   rinc        FIFO pop
//   flush       synchronous discard of buffered words
//   m_valid     output stream valid
//   m_data      output stream data
//   m_ready     output stream ready
//   buf_level   buffered word count (0..2)
//   beat_cnt    completed output handshakes, wrapping
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_level,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  // The state encoding is the buffered word count itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  push;
  logic                  fire;

  assign m_valid   = (state_q != StEmpty);
  assign fire      = m_valid && m_ready;
  assign rinc      = !rrst && !flush && !rempty && (state_q != StFull);
  assign push      = rinc;
  assign m_data    = head_q;
  assign buf_level = state_q;
  assign beat_cnt  = beat_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    beat_d  = beat_q + CNT_WIDTH'(fire);
    if (flush) begin
      // Words already accepted by the consumer in this cycle still count in beat_d.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = rdata;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && fire) begin
            head_d = rdata;
          end else if (push) begin
            skid_d  = rdata;
            state_d = StFull;
          end else if (fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (fire) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. The FIFO is a queue in the bench. Popped words
// go into a scoreboard queue and are compared when the consumer takes them.
// A second instance with a 4-bit beat counter shares the same stimulus and
// exercises counter wrap.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        rinc4;
  logic        flush;
  logic        m_valid;
  logic        m_valid4;
  logic [7:0]  m_data;
  logic [7:0]  m_data4;
  logic        m_ready;
  logic [1:0]  buf_level;
  logic [1:0]  buf_level4;
  logic [15:0] beat_cnt;
  logic [3:0]  beat_cnt4;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .buf_level (buf_level),
    .beat_cnt  (beat_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc4),
    .flush     (flush),
    .m_valid   (m_valid4),
    .m_data    (m_data4),
    .m_ready   (m_ready),
    .buf_level (buf_level4),
    .beat_cnt  (beat_cnt4)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         beat_model = 0;
  int         pops = 0;
  int         fires = 0;
  int         max_level = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, then update the models at the rising edge.
  task automatic step();
    logic s_rinc;
    logic s_fire;
    int   lvl;
    @(negedge rclk);
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
    #1;
    lvl    = exp_q.size();
    s_rinc = !rrst && !flush && !rempty && (lvl != 2);
    s_fire = (lvl != 0) && m_ready;
    check_eq("rinc", {31'd0, rinc}, {31'd0, s_rinc});
    check_eq("rinc_w4", {31'd0, rinc4}, {31'd0, s_rinc});
    check_eq("m_valid", {31'd0, m_valid}, {31'd0, lvl != 0});
    check_eq("buf_level", {30'd0, buf_level}, lvl);
    check_eq("beat_cnt", {16'd0, beat_cnt}, beat_model & 32'hffff);
    check_eq("beat_cnt_w4", {28'd0, beat_cnt4}, beat_model & 32'hf);
    if (lvl != 0) check_eq("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
    if (int'(buf_level) > max_level) max_level = int'(buf_level);
    if (s_fire) last_data = m_data;
    @(posedge rclk);
    if (rrst) begin
      exp_q.delete();
      beat_model = 0;
    end else begin
      if (s_fire) begin
        void'(exp_q.pop_front());
        beat_model++;
        fires++;
      end
      if (flush) begin
        exp_q.delete();
      end else if (s_rinc) begin
        exp_q.push_back(fifo_q.pop_front());
        pops++;
      end
    end
    #1;
  endtask

  logic pat [5];
  int   c;
  int   first;
  int   f0;
  int   p0;
  int   b0;

  initial begin
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = 8'h00;

    // Reset held 3 cycles with the FIFO already loaded.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    repeat (3) step();
    check_eq("reset_level", {30'd0, buf_level}, 0);
    check_eq("reset_fifo_untouched", fifo_q.size(), 16);

    // Streaming with m_ready held high.
    rrst = 1'b0; m_ready = 1'b1;
    c = 0;
    while (fifo_q.size() > 0 && c < 40) begin
      step();
      c++;
    end
    check_eq("stream_rinc_run", c, 16);
    repeat (2) step();
    check_eq("stream_beats", {16'd0, beat_cnt}, 16);
    check_eq("stream_level_end", {30'd0, buf_level}, 0);
    check_eq("stream_last", {24'd0, last_data}, 32'h10);

    // Backpressure.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hA0 + 8'(i));
    p0 = pops;
    repeat (5) step();
    check_eq("bp_pops", pops - p0, 2);
    check_eq("bp_level", {30'd0, buf_level}, 2);
    check_eq("bp_head", {24'd0, m_data}, 32'hA0);
    m_ready = 1'b1;
    f0 = fires; c = 0; first = -1;
    while (fires - f0 < 6 && c < 30) begin
      step();
      c++;
      if (first < 0 && fires > f0) first = c;
    end
    check_eq("bp_delivered", fires - f0, 6);
    check_eq("bp_gapless", c - first, 5);
    check_eq("bp_last", {24'd0, last_data}, 32'hA5);

    // Toggling ready.
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
    b0 = beat_model; max_level = 0; c = 0;
    while ((fifo_q.size() + exp_q.size()) > 0 && c < 60) begin
      m_ready = pat[c % 5];
      step();
      c++;
    end
    check_eq("tog_beats", {16'd0, beat_cnt}, (b0 + 10) & 32'hffff);
    check_eq("tog_max_level", (max_level <= 2) ? 1 : 0, 1);
    check_eq("tog_last", {24'd0, last_data}, 32'h39);

    // Flush with a full buffer and one word left in the FIFO.
    m_ready = 1'b0;
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h66); fifo_q.push_back(8'h77);
    repeat (3) step();
    check_eq("fl_level_before", {30'd0, buf_level}, 2);
    flush = 1'b1;
    #1;
    check_eq("fl_rinc", {31'd0, rinc}, 0);
    step();
    flush = 1'b0;
    check_eq("fl_level_after", {30'd0, buf_level}, 0);
    m_ready = 1'b1;
    f0 = fires; c = 0;
    while (fires == f0 && c < 20) begin
      step();
      c++;
    end
    check_eq("fl_next_word", {24'd0, last_data}, 32'h77);
    repeat (2) step();

    // Counter wrap on the 4-bit instance.
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'h80 + 8'(i));
    c = 0;
    while (beat_model < 16 && c < 40) begin
      step();
      c++;
    end
    check_eq("wrap16", {28'd0, beat_cnt4}, 0);
    c = 0;
    while (beat_model < 17 && c < 10) begin
      step();
      c++;
    end
    check_eq("wrap17", {28'd0, beat_cnt4}, 1);
    check_eq("wrap_wide", {16'd0, beat_cnt}, 17);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage for the asynchronous FIFO. Sits in the read clock domain directly downstream of the FIFO's read port: it drives the FIFO's read-increment, captures the popped word, and presents it to the consumer on a valid/ready stream through a 2-entry registered buffer. It sustains one word per cycle with no combinational path from consumer `m_ready` to FIFO `rinc`. It also keeps a free-running count of delivered beats for debug.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO's DATA_WIDTH.
- `CNT_WIDTH`, 16, width of the delivered-beat counter.

- `rclk`  in  1  read-domain clock; all logic on rising edge.
- `rrst`  in  1  reset, synchronous, active-high.
- `rempty`  in  1  FIFO empty flag (read domain).
- `rdata`  in  DATA_WIDTH  FIFO read data; valid in the same cycle the FIFO is non-empty (combinational memory read at current read address).
- `rinc`  out  1  FIFO read-increment (pop).
- `flush`  in  1  synchronous discard of buffered words.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  consumer accepts the word.
- `buf_level`  out  2  buffered word count, 0..2.
- `beat_cnt`  out  CNT_WIDTH  completed output handshakes, wraps modulo 2^CNT_WIDTH.

## Operation
- Storage consists of a head register `m_data`, a second register `skid`, and a level counter. State is encoded as `buf_level`: EMPTY=0, ONE=1, FULL=2. Level 3 is illegal and never reached.
- Pop condition:
  - `rinc = !rrst && !flush && !rempty && (buf_level != 2)`.
  - `rinc` depends only on registered state and `rempty`/`flush`, never on `m_ready`.
- Push: `push = rinc`. In that cycle `rdata` is captured at the clock edge.
- Output: `m_valid = (buf_level != 0)`, driven by register. Handshake: `fire = m_valid && m_ready`.
- Transitions (no flush):
  - EMPTY, push: `m_data <= rdata`; go to ONE.
  - ONE, push only: `skid <= rdata`; go to FULL.
  - ONE, fire only: go to EMPTY.
  - ONE, push and fire: `m_data <= rdata`; stay in ONE.
  - FULL, fire: `m_data <= skid`; go to ONE. Push cannot occur in FULL.
  - Any other combination: hold.
- Ordering: words leave in exactly the order popped; no duplication, no loss.
- `m_data` stays stable while `m_valid && !m_ready`.
- `flush`:
  - Forces `rinc=0`.
  - Next state is EMPTY.
  - A `fire` in the flush cycle still counts in `beat_cnt`; the consumer saw it accepted.
  - Buffered words are discarded. Words still in the FIFO are untouched.
- `beat_cnt` increments by 1 on every `fire`, wrapping from 2^CNT_WIDTH−1 to 0.
- Reset:
  - `buf_level=0`, `m_valid=0`, `m_data=0`, `skid=0`, `beat_cnt=0`.
  - `rinc=0` while `rrst` is high.
  - Reset mid-stream drops buffered words without popping further. The FIFO's own pointers are reset by its own reset.

## Timing
- Latency: word popped (`rinc=1`) in cycle N appears on `m_data` with `m_valid=1` in cycle N+1.
- Throughput:
  - 1 word/cycle steady state with `m_ready` held high and FIFO non-empty; level stays at 1.
  - With `m_ready` low, at most 2 words are popped before `rinc` drops.
  - After `m_ready` rises, the first `fire` occurs the same cycle and `rinc` reasserts in the following cycle.
- `buf_level`, `m_valid`, `m_data`, `beat_cnt` are registered outputs. `rinc` is combinational from registered state, `rempty`, `flush` and `rrst`.
- `rempty` may deassert late (synchronizer delay); the block only reacts in the cycle it sees `rempty=0`.

## Test plan
- Reset check: assert `rrst` 3 cycles with FIFO non-empty. Required: `rinc=0`, `m_valid=0`, `buf_level=0`, `beat_cnt=0`. Popping starts the first cycle after release.
- Streaming: preload FIFO with 0x01..0x10 (16 words), hold `m_ready=1`. Required:
  - `rinc` high 16 consecutive cycles.
  - `m_data` 0x01..0x10 on consecutive cycles, first one cycle after first `rinc`.
  - `beat_cnt=16`, then `buf_level=0`.
- Backpressure: load 0xA0..0xA5, hold `m_ready=0`. Required:
  - Exactly 2 pops; `buf_level=2`; `m_data=0xA0` stable.
  - `rinc=0` thereafter.
  - Release `m_ready`: output 0xA0..0xA5 in order, no gaps after the first.
- Toggling ready: `m_ready` pattern 1,0,1,1,0 over a 10-word stream (0x30..0x39). Required: data order exact, no duplicate, `beat_cnt=10`, `buf_level` never exceeds 2.
- Flush: with `buf_level=2` holding 0x55,0x66 and FIFO holding 0x77, pulse `flush` with `m_ready=0`. Required:
  - `rinc=0` in flush cycle.
  - `buf_level=0` next cycle.
  - 0x77 is the next word delivered; 0x55/0x66 never delivered.
- Counter wrap: set `CNT_WIDTH=4` and stream 17 words. Required: `beat_cnt` reads 0 after the 16th handshake and 1 after the 17th.
